// File: rtl/symdec_pkg.sv
// symdec_pkg: shared code definitions for the 4-bit symbol decoder.
//   CODE_SYM0..3 : legal one-hot-ish codes for symbols 0..3
//   sym_t        : decoded 2-bit symbol
//   dec_t        : {illegal, sym} result of decode_code()
package symdec_pkg;

  localparam logic [3:0] CODE_SYM0 = 4'd0;
  localparam logic [3:0] CODE_SYM1 = 4'd2;
  localparam logic [3:0] CODE_SYM2 = 4'd4;
  localparam logic [3:0] CODE_SYM3 = 4'd8;

  typedef logic [1:0] sym_t;

  typedef struct packed {
    logic illegal;
    sym_t sym;
  } dec_t;

  // Illegal codes decode as symbol 0 with the illegal flag raised.
  function automatic dec_t decode_code(input logic [3:0] code);
    dec_t d;
    d.illegal = 1'b0;
    d.sym     = 2'd0;
    case (code)
      CODE_SYM0: d.sym = 2'd0;
      CODE_SYM1: d.sym = 2'd1;
      CODE_SYM2: d.sym = 2'd2;
      CODE_SYM3: d.sym = 2'd3;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/symdec_lookup.sv
// symdec_lookup: combinational code-to-symbol lookup.
//   i_code    : 4-bit coded symbol
//   o_sym     : decoded 2-bit symbol (0 for illegal codes)
//   o_illegal : code is not one of the four legal values
module symdec_lookup
  import symdec_pkg::*;
(
  input  logic [3:0] i_code,
  output sym_t       o_sym,
  output logic       o_illegal
);

  dec_t w_dec;

  assign w_dec     = decode_code(i_code);
  assign o_sym     = w_dec.sym;
  assign o_illegal = w_dec.illegal;

endmodule

// File: rtl/symbol_pack_decoder.sv
// symbol_pack_decoder: decodes 4-bit coded symbols and packs SYMS_PER_WORD
// of them LSB-first into one output word.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_code/in_valid/in_ready     : input symbol handshake
//   flush               : emit the partial word when the output slot is free
//   out_data/out_valid/out_ready  : output word handshake
//   out_err             : word contains at least one illegal code
//   out_partial         : word emitted by flush with fewer than SYMS_PER_WORD symbols
//   err_cnt             : saturating count of accepted illegal codes
// Build option SYMDEC_ERR_DROP_EN: words with an illegal code are discarded
// instead of emitted, and out_err is tied low.
module symbol_pack_decoder
  import symdec_pkg::*;
#(
  parameter int unsigned SYMS_PER_WORD = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 in_code,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [2*SYMS_PER_WORD-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_err,
  output logic                       out_partial,
  output logic [ERR_CNT_W-1:0]       err_cnt
);

  localparam int unsigned OUT_W = 2 * SYMS_PER_WORD;
  localparam int unsigned IDX_W = $clog2(SYMS_PER_WORD);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  logic [IDX_W-1:0]     r_idx;
  logic [OUT_W-1:0]     r_asm;
  logic                 r_sticky;
  logic [OUT_W-1:0]     r_out_data;
  logic                 r_out_valid;
  logic                 r_out_partial;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  sym_t             w_sym;
  logic             w_illegal;
  logic             w_slot_free;
  logic             w_accept;
  logic             w_complete;
  logic             w_has_syms;
  logic             w_emit;
  logic             w_load;
  logic             w_word_err;
  logic [OUT_W-1:0] w_word;

  symdec_lookup u_lookup (
    .i_code    (in_code),
    .o_sym     (w_sym),
    .o_illegal (w_illegal)
  );

  // Only the completing symbol needs the output slot; earlier slots fill freely.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_idx != LAST_IDX) || w_slot_free;
  assign w_accept    = in_valid && in_ready;

  assign w_complete  = w_accept && (r_idx == LAST_IDX);
  assign w_has_syms  = (r_idx != '0) || w_accept;
  assign w_emit      = w_complete || (flush && w_slot_free && w_has_syms);
  assign w_word_err  = r_sticky || (w_accept && w_illegal);

  // Assembly word including the symbol accepted this cycle.
  always_comb begin
    w_word = r_asm;
    for (int unsigned k = 0; k < SYMS_PER_WORD; k++) begin
      if (w_accept && (r_idx == IDX_W'(k))) begin
        w_word[2*k +: 2] = w_sym;
      end
    end
  end

`ifdef SYMDEC_ERR_DROP_EN
  // Errored words are consumed from assembly but never reach the output.
  assign w_load  = w_emit && !w_word_err;
  assign out_err = 1'b0;
`else
  logic r_out_err;

  assign w_load  = w_emit;
  assign out_err = r_out_err;

  // Error flag of the word held in the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_err <= 1'b0;
    end else if (w_load) begin
      r_out_err <= w_word_err;
    end
  end
`endif

  // Output register, assembly state and error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_asm         <= '0;
      r_sticky      <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_partial <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_word;
        r_out_partial <= !w_complete;
      end else if (r_out_valid && out_ready) begin
        r_out_valid   <= 1'b0;
      end

      if (w_emit) begin
        r_idx    <= '0;
        r_asm    <= '0;
        r_sticky <= 1'b0;
      end else begin
        r_asm    <= w_word;
        r_sticky <= w_word_err;
        if (w_accept) begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end

      if (w_accept && w_illegal && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_partial = r_out_partial;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_symbol_pack_decoder.sv
// Testbench for symbol_pack_decoder: table-driven words, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
// A second instance with ERR_CNT_W=2 shares the inputs to check saturation.
module tb_symbol_pack_decoder;

  localparam int S = 4;
`ifdef SYMDEC_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_code;
  logic       in_valid;
  logic       in_ready, in_ready2;
  logic       flush;
  logic [7:0] out_data, out_data2;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic       out_err, out_err2;
  logic       out_partial, out_partial2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  symbol_pack_decoder #(.SYMS_PER_WORD(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
    .out_partial(out_partial), .err_cnt(err_cnt)
  );

  symbol_pack_decoder #(.SYMS_PER_WORD(4), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_err(out_err2),
    .out_partial(out_partial2), .err_cnt(err_cnt2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int legal[4] = '{0, 2, 4, 8};
  int m_q[$];
  bit m_sticky;
  bit m_ov;
  int m_od;
  bit m_oe;
  bit m_op;
  int m_ill;

  typedef struct {
    logic [15:0] codes;   // code k in bits [4k+3:4k]
    logic [7:0]  data;
    bit          err;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sticky = 1'b0;
    m_ov     = 1'b0;
    m_od     = 0;
    m_oe     = 1'b0;
    m_op     = 1'b0;
    m_ill    = 0;
  endtask

  // One clock: drive inputs, compare against model, advance model at the edge.
  task automatic cyc(input logic [3:0] c, input bit v, input bit f, input bit r);
    bit sf, ir, acc, ill;
    int sym, n, word;
    in_code = c; in_valid = v; flush = f; out_ready = r;
    #1;
    sf = !m_ov || r;
    ir = (m_q.size() != S - 1) || sf;
    check("in_ready",  32'(in_ready),  32'(ir));
    check("in_ready2", 32'(in_ready2), 32'(ir));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("err_cnt",   32'(err_cnt),   32'((m_ill > 255) ? 255 : m_ill));
    check("err_cnt2",  32'(err_cnt2),  32'((m_ill > 3) ? 3 : m_ill));
    if (m_ov) begin
      check("out_data",    32'(out_data),    32'(m_od));
      check("out_err",     32'(out_err),     32'(m_oe));
      check("out_partial", 32'(out_partial), 32'(m_op));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = v && ir;
      if (acc) begin
        ill = 1'b1;
        sym = 0;
        for (int k = 0; k < 4; k++) if (int'(c) == legal[k]) begin ill = 1'b0; sym = k; end
        m_q.push_back(sym);
        m_sticky = m_sticky | ill;
        if (ill) m_ill++;
      end
      n = m_q.size();
      if (m_ov && r) m_ov = 1'b0;
      if (n == S || (f && sf && n > 0)) begin
        word = 0;
        for (int k = 0; k < n; k++) word = word + (m_q[k] << (2 * k));
        if (!(DROP && m_sticky)) begin
          m_ov = 1'b1;
          m_od = word;
          m_oe = DROP ? 1'b0 : m_sticky;
          m_op = (n < S);
        end
        m_q.delete();
        m_sticky = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] cw;
    int nerr;
    bit v, f, r;
    logic [3:0] c;

    tbl[0] = '{16'h8420, 8'hE4, 1'b0};
    tbl[1] = '{16'h04D8, 8'h23, 1'b1};
    tbl[2] = '{16'h2222, 8'h55, 1'b0};
    tbl[3] = '{16'h2804, 8'h72, 1'b0};
    tbl[4] = '{16'hFFFF, 8'h00, 1'b1};

    rst_n = 1'b0; in_code = 4'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_data",    32'(out_data),    32'd0);
    check("rst_out_err",     32'(out_err),     32'd0);
    check("rst_out_partial", 32'(out_partial), 32'd0);
    check("rst_err_cnt",     32'(err_cnt),     32'd0);
    check("rst_in_ready",    32'(in_ready),    32'd1);

    // Table of full words with out_ready held high
    for (int i = 0; i < 5; i++) begin
      cw = tbl[i].codes;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) check("tbl_pre_valid", 32'(out_valid), 32'd0);
        cyc(cw[4*k +: 4], 1'b1, 1'b0, 1'b1);
      end
      check("tbl_valid", 32'(out_valid), 32'((DROP && tbl[i].err) ? 0 : 1));
      if (!(DROP && tbl[i].err)) begin
        check("tbl_data", 32'(out_data), 32'(tbl[i].data));
        check("tbl_err",  32'(out_err),  32'(tbl[i].err));
        check("tbl_part", 32'(out_partial), 32'd0);
      end
    end

    // Backpressure: hold E4 while assembling 2,2,2,2
    do_reset();
    cyc(4'd0, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1);
    cyc(4'd4, 1'b1, 1'b0, 1'b1); cyc(4'd8, 1'b1, 1'b0, 1'b1);
    check("bp_first", 32'(out_data), 32'hE4);
    for (int k = 0; k < 3; k++) cyc(4'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(4'd2, 1'b1, 1'b0, 1'b0);
    in_code = 4'd2; in_valid = 1'b1; out_ready = 1'b0; #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold",     32'(out_data), 32'hE4);
    check("bp_hold_v",   32'(out_valid), 32'd1);
    @(negedge clk);
    cyc(4'd2, 1'b1, 1'b0, 1'b1);
    check("bp_next_v",  32'(out_valid), 32'd1);
    check("bp_next",    32'(out_data),  32'h55);

    // Flush of a partial word, then flush with nothing assembled
    do_reset();
    cyc(4'd4, 1'b1, 1'b0, 1'b1); cyc(4'd8, 1'b1, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1, 1'b1);
    check("fl_valid", 32'(out_valid),   32'd1);
    check("fl_data",  32'(out_data),    32'h0E);
    check("fl_part",  32'(out_partial), 32'd1);
    cyc(4'd0, 1'b0, 1'b1, 1'b1);
    check("fl_empty", 32'(out_valid), 32'd0);
    // Flush together with the completing symbol is a full word
    cyc(4'd2, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1);
    cyc(4'd8, 1'b1, 1'b1, 1'b1);
    check("fl_full_data", 32'(out_data),    32'hD5);
    check("fl_full_part", 32'(out_partial), 32'd0);

    // Reset mid-word discards the partial word
    do_reset();
    cyc(4'd2, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1);
    do_reset();
    check("mr_valid0", 32'(out_valid), 32'd0);
    cyc(4'd0, 1'b1, 1'b0, 1'b1); cyc(4'd0, 1'b1, 1'b0, 1'b1);
    cyc(4'd0, 1'b1, 1'b0, 1'b1); cyc(4'd2, 1'b1, 1'b0, 1'b1);
    check("mr_valid", 32'(out_valid), 32'd1);
    check("mr_data",  32'(out_data),  32'h40);
    check("mr_cnt",   32'(err_cnt),   32'd0);

    // Saturation: eight illegal codes, 2-bit counter holds at 3
    do_reset();
    nerr = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(4'hF, 1'b1, 1'b0, 1'b1);
      if (k == 2) check("sat_cnt2_3rd", 32'(err_cnt2), 32'd3);
      if (out_valid && out_err) nerr++;
    end
    check("sat_cnt2", 32'(err_cnt2), 32'd3);
    check("sat_cnt",  32'(err_cnt),  32'd8);
    check("sat_words", 32'(nerr), 32'(DROP ? 0 : 2));
    for (int k = 0; k < 260; k++) cyc(4'hF, 1'b1, 1'b0, 1'b1);
    check("sat_cnt8", 32'(err_cnt), 32'd255);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) c = 4'($urandom_range(15));
      else c = 4'(legal[$urandom_range(3)]);
      v = ($urandom_range(3) != 0);
      f = ($urandom_range(15) == 0);
      r = ($urandom_range(3) != 0);
      if ($urandom_range(399) == 0) rst_n = 1'b0;
      cyc(c, v, f, r);
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/symbol_pack_decoder.md
Name: symbol_pack_decoder

Overview:
Receive-side counterpart of the team's 2-bit to 4-bit symbol encoder. Accepts a stream of 4-bit coded symbols over a valid/ready handshake and decodes each to its 2-bit value (code 0->0, 2->1, 4->2, 8->3). Packs SYMS_PER_WORD decoded symbols, LSB-first, into one output word on a second valid/ready handshake. Flags illegal codes per word and keeps a saturating count of them.

Parameters:
SYMS_PER_WORD, 4, decoded symbols per output word (>=2); output width OUT_W = 2*SYMS_PER_WORD
ERR_CNT_W, 8, width of the saturating illegal-code counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_code  input  4  coded symbol
in_valid  input  1  in_code valid
in_ready  output  1  block accepts in_code this cycle
flush  input  1  level; emit the partial word when possible
out_data  output  OUT_W  packed decoded word; symbol k occupies bits [2k+1:2k]
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_err  output  1  the word contains at least one illegal code
out_partial  output  1  the word was emitted by flush with fewer than SYMS_PER_WORD symbols
err_cnt  output  ERR_CNT_W  saturating count of illegal codes accepted

Behaviour:
- Reset: sampled on clk edge while rst_n=0. Clears out_valid, out_data, out_err, out_partial, err_cnt, symbol index, assembly register and sticky error to 0. Reset mid-word discards the partial word with no output. in_ready=1 from the first cycle after reset.
- Accept: a symbol is consumed on a clk edge with in_valid && in_ready.
- Decode: legal codes are 0, 2, 4 and 8. Any other value is illegal: it decodes as 2'b00, sets the word's sticky error, and increments err_cnt, which holds at all-ones.
- Assembly: symbol index idx runs 0..SYMS_PER_WORD-1. An accepted symbol is written to slot idx and idx increments. The completing symbol wraps idx to 0.
- Output slot free: slot_free = !out_valid || out_ready.
- in_ready: 1 when idx != SYMS_PER_WORD-1; otherwise equals slot_free. Combinational from registered state and out_ready only, never from in_valid.
- Emit on completion: on the edge that accepts the last symbol, the output register loads the full word, including that symbol. Effects: out_valid=1, out_err=sticky error including this symbol, out_partial=0. Assembly register and sticky error clear. Latency is one cycle from the accepting edge to out_valid.
- Emit on flush: on an edge with flush=1 and slot_free, if n>0 the word is emitted. Here n = idx plus 1 if a symbol is accepted that same edge. Unfilled upper slots are zero and out_partial=1 unless n==SYMS_PER_WORD. If n==0, flush has no effect. Flush coinciding with a completing symbol is an ordinary full word with out_partial=0.
- Hold: while out_valid && !out_ready, out_data, out_err and out_partial remain stable. Assembly of slots 0..SYMS_PER_WORD-2 continues.
- Drain: an output handshake with no new emit clears out_valid the next cycle. Output handshake and new emit on the same edge give back-to-back words with no bubble.

Optional Feature:
Macro SYMDEC_ERR_DROP_EN.
- Defined: a completed or flushed word whose sticky error is set is discarded. out_valid is not asserted, err_cnt still counts, and out_err is tied 0.
- Undefined: errored words are emitted with out_err=1, as described above.

Decomposition:
- Package symdec_pkg holds:
  - localparams CODE_SYM0=4'd0, CODE_SYM1=4'd2, CODE_SYM2=4'd4, CODE_SYM3=4'd8;
  - typedef sym_t (logic [1:0]);
  - function decode_code returning {illegal, sym_t}.
- One sub-module is natural: symdec_lookup, a combinational code-to-symbol lookup with an illegal flag, shared with the pipeline's other decoding points.
- The pack/handshake logic stays in the top module.

Test Plan:
- Defaults, out_ready=1; codes 0,2,4,8 -> out_data=8'hE4, out_err=0, out_partial=0, out_valid one cycle after the 4th accept.
- Codes 8,13,4,0 -> out_data=8'h23, out_err=1, err_cnt=1; with SYMDEC_ERR_DROP_EN defined: no out_valid, err_cnt=1.
- Backpressure: out_ready=0 after the first word 0xE4, then stream 2,2,2,2 -> in_ready=0 while presenting the 4th code and out_data held at 8'hE4. Raise out_ready -> next word 8'h55 with no lost symbol.
- Flush: codes 4,8 then flush=1 -> out_data=8'h0E, out_partial=1. Flush with idx=0 -> no output.
- Reset mid-word: accept 2,2,2, pulse rst_n=0 one cycle, then 0,0,0,2 -> single word 8'h40, err_cnt=0.
- ERR_CNT_W=2, eight illegal codes (e.g. 4'hF) -> err_cnt=3 after the third and stays 3; two words with out_err=1.
